// File: rtl/niu32_pkg.sv
// rtl/niu32_pkg.sv - Niu32 OP2 function codes and ALU state encoding
package niu32_pkg;

  localparam logic [4:0] OP2_SUB = 5'd0;
  localparam logic [4:0] OP2_ADD = 5'd1;
  localparam logic [4:0] OP2_MLT = 5'd2;
  localparam logic [4:0] OP2_DIV = 5'd3;
  localparam logic [4:0] OP2_NOT = 5'd4;
  localparam logic [4:0] OP2_AND = 5'd5;
  localparam logic [4:0] OP2_OR  = 5'd6;
  localparam logic [4:0] OP2_XOR = 5'd7;
  localparam logic [4:0] OP2_SUL = 5'd8;
  localparam logic [4:0] OP2_SSL = 5'd9;
  localparam logic [4:0] OP2_SUR = 5'd10;
  localparam logic [4:0] OP2_SSR = 5'd11;
  localparam logic [4:0] OP2_EQ  = 5'd16;
  localparam logic [4:0] OP2_NEQ = 5'd17;
  localparam logic [4:0] OP2_LT  = 5'd18;
  localparam logic [4:0] OP2_LEQ = 5'd19;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/niu_muldiv_core.sv
// rtl/niu_muldiv_core.sv - iterative unsigned shift-add multiply / restoring divide engine
module niu_muldiv_core #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 mode,
  input  logic                 step,
  input  logic [WORD_SIZE-1:0] a_mag,
  input  logic [WORD_SIZE-1:0] b_mag,
  output logic [WORD_SIZE-1:0] value,
  output logic                 last
);

  localparam int CNT_BITS = $clog2(WORD_SIZE);

  // acc: product (mul) or partial remainder (div); shreg: multiplier or dividend/quotient
  logic [WORD_SIZE:0]   acc;
  logic [WORD_SIZE-1:0] shreg;
  logic [WORD_SIZE-1:0] opnd;
  logic [CNT_BITS-1:0]  cnt;
  logic [WORD_SIZE:0]   rem_sh;
  logic [WORD_SIZE:0]   rem_diff;

  always_comb begin
    rem_sh   = {acc[WORD_SIZE-1:0], shreg[WORD_SIZE-1]};
    rem_diff = rem_sh - {1'b0, opnd};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      shreg <= '0;
      opnd  <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      shreg <= a_mag;
      opnd  <= b_mag;
      cnt   <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (mode) begin
        // borrow in the top bit means the divisor did not fit
        if (!rem_diff[WORD_SIZE]) begin
          acc   <= rem_diff;
          shreg <= {shreg[WORD_SIZE-2:0], 1'b1};
        end else begin
          acc   <= rem_sh;
          shreg <= {shreg[WORD_SIZE-2:0], 1'b0};
        end
      end else begin
        if (shreg[0]) begin
          acc <= {1'b0, acc[WORD_SIZE-1:0] + opnd};
        end
        opnd  <= opnd << 1;
        shreg <= shreg >> 1;
      end
    end
  end

  assign value = mode ? shreg : acc[WORD_SIZE-1:0];
  assign last  = (cnt == CNT_BITS'(WORD_SIZE - 1));

endmodule

// File: rtl/niu_iter_alu.sv
// rtl/niu_iter_alu.sv - Niu32 multicycle ALU: single-cycle ops plus iterative MLT/DIV
module niu_iter_alu
  import niu32_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int OP_BITS   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OP_BITS-1:0]   func,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic                 div_zero,
  output logic                 illegal
);

  localparam int SH_BITS = $clog2(WORD_SIZE);

  logic [2:0]           state;
  logic                 neg_q;
  logic                 mode_q;
  logic                 accept;
  logic [SH_BITS-1:0]   shamt;
  logic [WORD_SIZE-1:0] simple_res;
  logic                 simple_bad;
  logic [WORD_SIZE-1:0] a_mag;
  logic [WORD_SIZE-1:0] b_mag;
  logic [WORD_SIZE-1:0] core_value;
  logic                 core_last;

  assign accept = (state == ST_IDLE) && start;
  assign shamt  = b[SH_BITS-1:0];
  assign a_mag  = a[WORD_SIZE-1] ? -a : a;
  assign b_mag  = b[WORD_SIZE-1] ? -b : b;
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

  always_comb begin
    simple_res = '0;
    simple_bad = 1'b0;
    case (func)
      OP2_SUB: simple_res = a - b;
      OP2_ADD: simple_res = a + b;
      OP2_MLT, OP2_DIV: simple_res = '0;
      OP2_NOT: simple_res = ~a;
      OP2_AND: simple_res = a & b;
      OP2_OR:  simple_res = a | b;
      OP2_XOR: simple_res = a ^ b;
      OP2_SUL, OP2_SSL: simple_res = a << shamt;
      OP2_SUR: simple_res = a >> shamt;
      OP2_SSR: simple_res = $signed(a) >>> shamt;
      OP2_EQ:  simple_res = {{(WORD_SIZE-1){1'b0}}, (a == b)};
      OP2_NEQ: simple_res = {{(WORD_SIZE-1){1'b0}}, (a != b)};
      OP2_LT:  simple_res = {{(WORD_SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
      OP2_LEQ: simple_res = {{(WORD_SIZE-1){1'b0}}, ($signed(a) <= $signed(b))};
      default: simple_bad = 1'b1;
    endcase
  end

  niu_muldiv_core #(.WORD_SIZE(WORD_SIZE)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .mode  (mode_q),
    .step  ((state == ST_MUL) || (state == ST_DIV)),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .value (core_value),
    .last  (core_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      result   <= '0;
      div_zero <= 1'b0;
      illegal  <= 1'b0;
      neg_q    <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
            illegal  <= 1'b0;
            neg_q    <= a[WORD_SIZE-1] ^ b[WORD_SIZE-1];
            mode_q   <= (func == OP2_DIV);
            if (func == OP2_MLT) begin
              state <= ST_MUL;
            end else if (func == OP2_DIV && b == '0) begin
              result   <= '1;
              div_zero <= 1'b1;
              state    <= ST_DONE;
            end else if (func == OP2_DIV) begin
              state <= ST_DIV;
            end else begin
              result  <= simple_res;
              illegal <= simple_bad;
              state   <= ST_DONE;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (core_last) state <= ST_FIX;
        end
        ST_FIX: begin
          result <= neg_q ? -core_value : core_value;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
